// File: rtl/idex_operand_stage.sv
// rtl/idex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
//
// Captures decoded operands and shift-control fields at the decode boundary,
// resolves RAW hazards from MEM/WB and feeds the execute-stage shifter.
//
// Ports:
//   clk, reset (async, active-high), stall (hold all), flush (load bubble)
//   id_*          decode-slot instruction fields
//   mem_*, wb_*   downstream write-back candidates used for forwarding/hazards
//   hazard_stall  request to hold PC and IF/ID
//   ex_*          registered control for the execute stage
//   sh_*          operands and controls presented to the shifter
//
// Configuration macro: IDEX_FWD_EN
//   defined   - MEM/WB forwarding muxes on sh_a/sh_b, stall on load-use only
//   undefined - no forwarding; stall on any RAW dependency on EX or MEM
//               (WB is covered by the write-first register file)

module idex_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_writereg,
    input  logic [2:0]       id_shctrl,
    input  logic             id_lui,
    input  logic [4:0]       id_shamt,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_writereg,
    input  logic [WIDTH-1:0] mem_result,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_writereg,
    input  logic [WIDTH-1:0] wb_result,
    output logic             hazard_stall,
    output logic             ex_valid,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic [4:0]       ex_writereg,
    output logic [WIDTH-1:0] sh_a,
    output logic [WIDTH-1:0] sh_b,
    output logic [2:0]       sh_control,
    output logic             sh_lui,
    output logic [4:0]       sh_constshift
);

    logic             valid_q, valid_d;
    logic             regwrite_q, regwrite_d;
    logic             memread_q, memread_d;
    logic [4:0]       rs_q, rs_d;
    logic [4:0]       rt_q, rt_d;
    logic [4:0]       writereg_q, writereg_d;
    logic [WIDTH-1:0] rd1_q, rd1_d;
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic [2:0]       shctrl_q, shctrl_d;
    logic             lui_q, lui_d;
    logic [4:0]       shamt_q, shamt_d;

    logic load_use;
    logic raw_hazard;

    // A load in EX cannot be forwarded in time for a dependent in decode.
    assign load_use = valid_q & memread_q & (writereg_q != 5'd0) & id_valid &
                      ((writereg_q == id_rs) | (writereg_q == id_rt));

`ifdef IDEX_FWD_EN
    function automatic logic [WIDTH-1:0] fwd_sel(input logic [4:0]       src,
                                                 input logic [WIDTH-1:0] regval);
        // MEM is the younger producer, so it takes priority over WB.
        if (mem_regwrite && mem_writereg != 5'd0 && mem_writereg == src)
            fwd_sel = mem_result;
        else if (wb_regwrite && wb_writereg != 5'd0 && wb_writereg == src)
            fwd_sel = wb_result;
        else
            fwd_sel = regval;
    endfunction

    assign raw_hazard = 1'b0;
    assign sh_a = fwd_sel(rs_q, rd1_q);
    assign sh_b = fwd_sel(rt_q, rd2_q);
`else
    logic ex_dep;
    logic mem_dep;
    logic unused_nofwd;

    // Without forwarding the dependent waits until its producer reaches WB,
    // where the write-first register file supplies the value in decode.
    assign ex_dep  = valid_q & regwrite_q &
                     (((id_rs != 5'd0) & (id_rs == writereg_q)) |
                      ((id_rt != 5'd0) & (id_rt == writereg_q)));
    assign mem_dep = mem_regwrite &
                     (((id_rs != 5'd0) & (id_rs == mem_writereg)) |
                      ((id_rt != 5'd0) & (id_rt == mem_writereg)));
    assign raw_hazard = id_valid & (ex_dep | mem_dep);
    assign sh_a = rd1_q;
    assign sh_b = rd2_q;
    assign unused_nofwd = ^{wb_regwrite, wb_writereg, wb_result, rs_q, rt_q};
`endif

    assign hazard_stall = ~flush & (load_use | raw_hazard);

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        writereg_d = writereg_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        shctrl_d   = shctrl_q;
        lui_d      = lui_q;
        shamt_d    = shamt_q;
        if (flush || (!stall && hazard_stall)) begin
            // Bubble: every field zeroed so the shifter sees a clean no-op.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            writereg_d = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            shctrl_d   = '0;
            lui_d      = 1'b0;
            shamt_d    = '0;
        end else if (!stall) begin
            valid_d    = id_valid;
            regwrite_d = id_regwrite & id_valid;
            memread_d  = id_memread & id_valid;
            rs_d       = id_rs;
            rt_d       = id_rt;
            writereg_d = id_writereg;
            rd1_d      = id_rd1;
            rd2_d      = id_rd2;
            shctrl_d   = id_shctrl;
            lui_d      = id_lui;
            shamt_d    = id_shamt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            writereg_q <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            shctrl_q   <= '0;
            lui_q      <= 1'b0;
            shamt_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            writereg_q <= writereg_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            shctrl_q   <= shctrl_d;
            lui_q      <= lui_d;
            shamt_q    <= shamt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_writereg   = writereg_q;
    assign sh_control    = shctrl_q;
    assign sh_lui        = lui_q;
    assign sh_constshift = shamt_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// tb/tb_idex_operand_stage.sv - directed self-checking bench for idex_operand_stage

module tb_idex_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_rd1, id_rd2;
    logic [4:0]  id_rs, id_rt, id_writereg;
    logic [2:0]  id_shctrl;
    logic        id_lui;
    logic [4:0]  id_shamt;
    logic        id_regwrite, id_memread;
    logic        mem_regwrite;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_result;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_result;
    logic        hazard_stall, ex_valid, ex_regwrite, ex_memread;
    logic [4:0]  ex_writereg;
    logic [31:0] sh_a, sh_b;
    logic [2:0]  sh_control;
    logic        sh_lui;
    logic [4:0]  sh_constshift;

    int checks = 0;
    int failures = 0;

    idex_operand_stage #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2),
        .id_rs(id_rs), .id_rt(id_rt), .id_writereg(id_writereg),
        .id_shctrl(id_shctrl), .id_lui(id_lui), .id_shamt(id_shamt),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg),
        .sh_a(sh_a), .sh_b(sh_b), .sh_control(sh_control), .sh_lui(sh_lui),
        .sh_constshift(sh_constshift)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; flush = 0; id_valid = 0;
        id_rd1 = 0; id_rd2 = 0; id_rs = 0; id_rt = 0; id_writereg = 0;
        id_shctrl = 0; id_lui = 0; id_shamt = 0; id_regwrite = 0; id_memread = 0;
        mem_regwrite = 0; mem_writereg = 0; mem_result = 0;
        wb_regwrite = 0; wb_writereg = 0; wb_result = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
        checks++; if (sh_control !== 3'd0) begin failures++; $display("FAIL reset_sh_control got=%0h exp=0", sh_control); end
        checks++; if (sh_lui !== 1'b0) begin failures++; $display("FAIL reset_sh_lui got=%0h exp=0", sh_lui); end
        checks++; if (sh_constshift !== 5'd0) begin failures++; $display("FAIL reset_sh_constshift got=%0h exp=0", sh_constshift); end
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0h exp=0", hazard_stall); end
        checks++; if (sh_a !== 32'd0) begin failures++; $display("FAIL reset_sh_a got=%0h exp=0", sh_a); end
        reset = 0;
        step();
    endtask

    task automatic test_reset_mid();
        idle();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_writereg = 4;
        id_shctrl = 5; id_lui = 1; id_shamt = 7; id_rd1 = 32'h11; id_rd2 = 32'h22;
        id_rs = 1; id_rt = 2;
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL load_ex_valid got=%0h exp=1", ex_valid); end
        checks++; if (sh_control !== 3'd5) begin failures++; $display("FAIL load_sh_control got=%0h exp=5", sh_control); end
        checks++; if (sh_constshift !== 5'd7) begin failures++; $display("FAIL load_sh_constshift got=%0h exp=7", sh_constshift); end
        checks++; if (sh_a !== 32'h11) begin failures++; $display("FAIL load_sh_a got=%0h exp=11", sh_a); end
        checks++; if (ex_writereg !== 5'd4) begin failures++; $display("FAIL load_ex_writereg got=%0h exp=4", ex_writereg); end
        id_memread = 0; id_rs = 4; id_writereg = 9;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL pre_reset_hazard got=%0h exp=1", hazard_stall); end
        #2 reset = 1;
        #1;
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL midreset_ex_valid got=%0h exp=0", ex_valid); end
        checks++; if (sh_control !== 3'd0) begin failures++; $display("FAIL midreset_sh_control got=%0h exp=0", sh_control); end
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL midreset_hazard got=%0h exp=0", hazard_stall); end
        reset = 0;
        idle();
        step();
    endtask

    task automatic test_forwarding();
        idle();
        id_valid = 1; id_rs = 5; id_rd1 = 32'h77; id_rt = 6; id_rd2 = 32'h66;
        step();
        id_valid = 0;
        mem_regwrite = 1; mem_writereg = 5; mem_result = 32'h3;
        wb_regwrite = 1; wb_writereg = 5; wb_result = 32'h1F;
        #1;
`ifdef IDEX_FWD_EN
        checks++; if (sh_a !== 32'h3) begin failures++; $display("FAIL fwd_mem_over_wb got=%0h exp=3", sh_a); end
`else
        checks++; if (sh_a !== 32'h77) begin failures++; $display("FAIL nofwd_sh_a got=%0h exp=77", sh_a); end
`endif
        mem_writereg = 0;
        #1;
`ifdef IDEX_FWD_EN
        checks++; if (sh_a !== 32'h1F) begin failures++; $display("FAIL fwd_wb got=%0h exp=1f", sh_a); end
`else
        checks++; if (sh_a !== 32'h77) begin failures++; $display("FAIL nofwd_sh_a2 got=%0h exp=77", sh_a); end
`endif
        mem_writereg = 6;
        #1;
`ifdef IDEX_FWD_EN
        checks++; if (sh_b !== 32'h3) begin failures++; $display("FAIL fwd_sh_b_mem got=%0h exp=3", sh_b); end
`else
        checks++; if (sh_b !== 32'h66) begin failures++; $display("FAIL nofwd_sh_b got=%0h exp=66", sh_b); end
`endif
        idle();
        step();
    endtask

    task automatic test_load_use();
        idle();
        id_valid = 1; id_memread = 1; id_regwrite = 1; id_writereg = 8; id_rs = 1; id_rt = 2;
        step();
        id_memread = 0; id_rs = 9; id_rt = 8; id_rd2 = 32'hBAD; id_writereg = 10;
        #1;
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL loaduse_hazard got=%0h exp=1", hazard_stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got=%0h exp=0", ex_valid); end
        mem_regwrite = 1; mem_writereg = 8; mem_result = 32'h1234_5678;
        #1;
`ifdef IDEX_FWD_EN
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL loaduse_one_cycle got=%0h exp=0", hazard_stall); end
`else
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL nofwd_mem_dep got=%0h exp=1", hazard_stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL nofwd_bubble2 got=%0h exp=0", ex_valid); end
        mem_regwrite = 0; mem_writereg = 0;
        wb_regwrite = 1; wb_writereg = 8; wb_result = 32'h1234_5678;
        id_rd2 = 32'h1234_5678;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL nofwd_wb_nostall got=%0h exp=0", hazard_stall); end
`endif
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL loaduse_issue got=%0h exp=1", ex_valid); end
        checks++; if (sh_b !== 32'h1234_5678) begin failures++; $display("FAIL loaduse_sh_b got=%0h exp=12345678", sh_b); end
        checks++; if (ex_writereg !== 5'd10) begin failures++; $display("FAIL loaduse_writereg got=%0h exp=a", ex_writereg); end
        idle();
        step();
    endtask

    task automatic test_stall_flush();
        idle();
        id_valid = 1; id_regwrite = 1; id_writereg = 11; id_rs = 12; id_rt = 13;
        id_shctrl = 3; id_shamt = 9; id_rd1 = 32'hA1; id_rd2 = 32'hA2;
        step();
        stall = 1;
        id_writereg = 14; id_rs = 15; id_rt = 16; id_shctrl = 6; id_lui = 1;
        id_shamt = 2; id_rd1 = 32'hB1; id_rd2 = 32'hB2; id_regwrite = 0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL stall_ex_valid got=%0h exp=1", ex_valid); end
        checks++; if (ex_regwrite !== 1'b1) begin failures++; $display("FAIL stall_ex_regwrite got=%0h exp=1", ex_regwrite); end
        checks++; if (ex_writereg !== 5'd11) begin failures++; $display("FAIL stall_ex_writereg got=%0h exp=b", ex_writereg); end
        checks++; if (sh_control !== 3'd3) begin failures++; $display("FAIL stall_sh_control got=%0h exp=3", sh_control); end
        checks++; if (sh_lui !== 1'b0) begin failures++; $display("FAIL stall_sh_lui got=%0h exp=0", sh_lui); end
        checks++; if (sh_constshift !== 5'd9) begin failures++; $display("FAIL stall_sh_constshift got=%0h exp=9", sh_constshift); end
        checks++; if (sh_a !== 32'hA1) begin failures++; $display("FAIL stall_sh_a got=%0h exp=a1", sh_a); end
        checks++; if (sh_b !== 32'hA2) begin failures++; $display("FAIL stall_sh_b got=%0h exp=a2", sh_b); end
        flush = 1; id_rs = 11;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL flush_masks_hazard got=%0h exp=0", hazard_stall); end
        step();
        checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_over_stall got=%0h exp=0", ex_valid); end
        checks++; if (ex_regwrite !== 1'b0) begin failures++; $display("FAIL flush_regwrite got=%0h exp=0", ex_regwrite); end
        idle();
        step();
    endtask

    task automatic test_r0();
        idle();
        mem_regwrite = 1; mem_writereg = 0; mem_result = 32'hDEAD;
        wb_regwrite = 1; wb_writereg = 0; wb_result = 32'hBEEF;
        id_valid = 1; id_rs = 0; id_rt = 0; id_rd1 = 0; id_rd2 = 0;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL r0_hazard got=%0h exp=0", hazard_stall); end
        step();
        checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL r0_ex_valid got=%0h exp=1", ex_valid); end
        checks++; if (sh_a !== 32'd0) begin failures++; $display("FAIL r0_sh_a got=%0h exp=0", sh_a); end
        checks++; if (sh_b !== 32'd0) begin failures++; $display("FAIL r0_sh_b got=%0h exp=0", sh_b); end
        idle();
        step();
    endtask

    task automatic test_config();
        idle();
        id_valid = 1; id_regwrite = 1; id_writereg = 3; id_rs = 1; id_rt = 2;
        step();
        id_regwrite = 0; id_writereg = 7; id_rs = 3; id_rt = 4;
        #1;
`ifdef IDEX_FWD_EN
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL cfg_fwd_no_hazard got=%0h exp=0", hazard_stall); end
`else
        checks++; if (hazard_stall !== 1'b1) begin failures++; $display("FAIL cfg_nofwd_hazard got=%0h exp=1", hazard_stall); end
`endif
        id_valid = 0;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL cfg_invalid_no_hazard got=%0h exp=0", hazard_stall); end
        idle();
        step();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_reset_mid();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_r0();
        test_config();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idex_operand_stage.md
# idex_operand_stage

ID/EX pipeline register and operand-forwarding stage of the execute path. It captures decoded operands and shift-control fields at the decode boundary and resolves RAW hazards from the MEM and WB stages. It presents the execute-stage shifter with final `a`, `b`, `control`, `lui` and `constshift` values. It also detects load-use hazards and requests a decode stall, inserting a bubble into execute.

## Interface
Parameters:
- `WIDTH`, 32, datapath width of register operands and forwarded results.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  downstream hold; freezes every register in this block.
- `flush`  in  1  squash; loads a bubble on the next edge.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_rd1`, `id_rd2`  in  WIDTH  register-file read data for rs and rt.
- `id_rs`, `id_rt`, `id_writereg`  in  5  source and destination register numbers.
- `id_shctrl`  in  3  shifter control field.
- `id_lui`  in  1  lui select.
- `id_shamt`  in  5  instruction shamt field.
- `id_regwrite`, `id_memread`  in  1  writeback-enable and load flags.
- `mem_regwrite`  in  1  MEM-stage write-back valid.
- `mem_writereg`  in  5  MEM-stage destination.
- `mem_result`  in  WIDTH  MEM-stage value.
- `wb_regwrite`  in  1  WB-stage write-back valid.
- `wb_writereg`  in  5  WB-stage destination.
- `wb_result`  in  WIDTH  WB-stage value.
- `hazard_stall`  out  1  request to hold PC and IF/ID.
- `ex_valid`, `ex_regwrite`, `ex_memread`  out  1  registered control.
- `ex_writereg`  out  5  registered destination.
- `sh_a`, `sh_b`  out  WIDTH  forwarded operands to the shifter.
- `sh_control`  out  3  registered shift control.
- `sh_lui`  out  1  registered lui select.
- `sh_constshift`  out  5  registered shamt.

## Operation
Registered state:
- valid, regwrite, memread, rs, rt, writereg, rd1, rd2, shctrl, lui, shamt.

Update priority on each rising edge (highest first):
1. `flush`: valid, regwrite and memread go to 0. Other fields are don't-care; implementation zeros them.
2. `stall`: all registers hold.
3. `hazard_stall`: bubble loaded, same as flush. The decode slot is retried on the next cycle because upstream holds it.
4. Otherwise: load all `id_*` fields. ex valid = `id_valid`; regwrite and memread are gated by `id_valid`.

Load-use detect (combinational):
- `hazard_stall` = `ex_valid & ex_memread & ex_writereg!=0 & id_valid & (ex_writereg==id_rs | ex_writereg==id_rt)`.
- `hazard_stall` is forced to 0 while `flush` is asserted.

Forwarding (combinational, applied independently to `sh_a` from rs/rd1 and `sh_b` from rt/rd2):
- MEM match: `mem_regwrite & mem_writereg!=0 & mem_writereg==src` selects `mem_result`.
- Otherwise WB match, with the same rule, selects `wb_result`.
- Otherwise the registered value.
- MEM wins over WB when both match. Register 0 is never forwarded.
- Outputs are driven whether or not `ex_valid` is set. Consumers qualify with `ex_valid`.

## Timing
- Reset values: all registered outputs are 0, so `sh_control`=0, `sh_lui`=0 and `sh_constshift`=0. `hazard_stall`=0. `sh_a`/`sh_b` equal forwarded results or 0.
- Decode-to-execute latency: 1 cycle.
- Forwarding is 0-cycle, with a combinational path from `mem_*`/`wb_*` to `sh_a`/`sh_b`.
- `hazard_stall` asserts in the same cycle the dependent instruction sits in decode. It lasts exactly 1 cycle per load unless `stall` is held. While `stall`=1 the bubble is not inserted and `hazard_stall` may remain asserted.
- When `flush` and `stall` are both asserted, flush wins.
- Reset mid-operation clears all state immediately. No pending bubble survives.

## Configuration
- `IDEX_FWD_EN` defined:
  - Forwarding muxes are present as described.
  - `hazard_stall` covers load-use only.
- `IDEX_FWD_EN` undefined:
  - `sh_a`=rd1 and `sh_b`=rd2 as registered, with no forwarding logic.
  - `hazard_stall` additionally asserts when `id_valid` and a nonzero rs or rt matches either `ex_writereg` (with `ex_regwrite & ex_valid`) or `mem_writereg` (with `mem_regwrite`).
  - The register file is write-first, so WB needs no stall.

## Test plan
- Reset asserted mid-cycle with loaded state -> `ex_valid`=0, `sh_control`=0 and `hazard_stall`=0 immediately, without waiting for a clock edge.
- `id_rs`=5 and `mem_writereg`=5 with `mem_result`=0x0000_0003, and simultaneously `wb_writereg`=5 with `wb_result`=0x1F -> `sh_a`=0x3. Change `mem_writereg` to 0 -> `sh_a`=0x1F.
- Execute stage holds a load to r8 and decode has `id_rt`=8 -> `hazard_stall`=1 for one cycle, then `ex_valid`=0 (bubble), then the instruction issues with `sh_b` forwarded from MEM.
- `stall`=1 for 3 cycles with new `id_*` values applied -> all `ex_*`/`sh_*` registered outputs unchanged. Assert `flush` while `stall`=1 -> `ex_valid`=0 after the edge.
- Writes to r0 from both MEM (`mem_result`=0xDEAD) and WB, with rs=0 and rd1=0 -> `sh_a`=0 and no hazard.
- With `IDEX_FWD_EN` undefined, `ex_writereg`=3 with regwrite and `id_rs`=3 -> `hazard_stall`=1. With `IDEX_FWD_EN` defined, the same stimulus -> `hazard_stall`=0.
